// File: rtl/mod0_bfly_stage.sv
// Radix-2 butterfly for FFT stage MOD0: pairs each input word with its HALF_DEPTH-delayed partner.
// Optional MOD0_BFLY_SCALE_EN halves the outputs with round-half-up; latency stays one clock.
module mod0_bfly_stage #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_LANES  = 16,
    parameter int HALF_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                din_valid,
    input  logic                                din_sop,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     din_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     din_q,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     dly_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     dly_q,
    input  logic                                err_clr,
    output logic                                dout_valid,
    output logic                                dout_sop,
    output logic                                dout_eop,
    output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] sum_i,
    output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] sum_q,
    output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] diff_i,
    output logic [NUM_LANES*(DATA_WIDTH+1)-1:0] diff_q,
    output logic                                frame_err
);
    localparam int OUT_WIDTH = DATA_WIDTH + 1;
    localparam int CNT_W     = (HALF_DEPTH > 1) ? $clog2(HALF_DEPTH) : 1;
`ifdef MOD0_BFLY_SCALE_EN
    localparam int ACC_W     = OUT_WIDTH + 1;
`else
    localparam int ACC_W     = OUT_WIDTH;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'((HALF_DEPTH == 1) ? 0 : 1);

    typedef enum logic [1:0] {IDLE, FILL, CALC} state_t;

    // With a one-word half, the sop word is also the last FILL word.
    localparam state_t SOP_STATE = (HALF_DEPTH == 1) ? CALC : FILL;

    function automatic logic signed [OUT_WIDTH-1:0] bfly(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b,
        input logic                         sub
    );
        logic signed [ACC_W-1:0] acc;
        acc = sub ? (ACC_W'(a) - ACC_W'(b)) : (ACC_W'(a) + ACC_W'(b));
`ifdef MOD0_BFLY_SCALE_EN
        return OUT_WIDTH'((acc + ACC_W'(1)) >>> 1);
`else
        return OUT_WIDTH'(acc);
`endif
    endfunction

    state_t                               state;
    logic [CNT_W-1:0]                     cnt;
    logic                                 vld_p1;
    logic                                 sop_p1;
    logic                                 eop_p1;
    logic [NUM_LANES*OUT_WIDTH-1:0]       sum_i_p1;
    logic [NUM_LANES*OUT_WIDTH-1:0]       sum_q_p1;
    logic [NUM_LANES*OUT_WIDTH-1:0]       diff_i_p1;
    logic [NUM_LANES*OUT_WIDTH-1:0]       diff_q_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            sop_p1    <= 1'b0;
            eop_p1    <= 1'b0;
            sum_i_p1  <= '0;
            sum_q_p1  <= '0;
            diff_i_p1 <= '0;
            diff_q_p1 <= '0;
            frame_err <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
            // A protocol error later in this block overrides the clear.
            if (err_clr) begin
                frame_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (din_valid && din_sop) begin
                        state <= SOP_STATE;
                        cnt   <= CNT_START;
                    end
                end
                FILL, CALC: begin
                    if (!din_valid) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        frame_err <= 1'b1;
                    end else if (din_sop) begin
                        state     <= SOP_STATE;
                        cnt       <= CNT_START;
                        frame_err <= 1'b1;
                    end else begin
                        if (state == CALC) begin
                            vld_p1 <= 1'b1;
                            sop_p1 <= (cnt == '0);
                            eop_p1 <= (cnt == CNT_LAST);
                            for (int l = 0; l < NUM_LANES; l++) begin
                                sum_i_p1[l*OUT_WIDTH +: OUT_WIDTH] <=
                                    bfly(dly_i[l*DATA_WIDTH +: DATA_WIDTH], din_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b0);
                                sum_q_p1[l*OUT_WIDTH +: OUT_WIDTH] <=
                                    bfly(dly_q[l*DATA_WIDTH +: DATA_WIDTH], din_q[l*DATA_WIDTH +: DATA_WIDTH], 1'b0);
                                diff_i_p1[l*OUT_WIDTH +: OUT_WIDTH] <=
                                    bfly(dly_i[l*DATA_WIDTH +: DATA_WIDTH], din_i[l*DATA_WIDTH +: DATA_WIDTH], 1'b1);
                                diff_q_p1[l*OUT_WIDTH +: OUT_WIDTH] <=
                                    bfly(dly_q[l*DATA_WIDTH +: DATA_WIDTH], din_q[l*DATA_WIDTH +: DATA_WIDTH], 1'b1);
                            end
                        end
                        if (cnt == CNT_LAST) begin
                            state <= (state == FILL) ? CALC : IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign dout_valid = vld_p1;
    assign dout_sop   = sop_p1;
    assign dout_eop   = eop_p1;
    assign sum_i      = sum_i_p1;
    assign sum_q      = sum_q_p1;
    assign diff_i     = diff_i_p1;
    assign diff_q     = diff_q_p1;

endmodule

// File: tb/tb_mod0_bfly_stage.sv
// Directed bench for mod0_bfly_stage with a queue of expected butterfly results.
module tb_mod0_bfly_stage;
    localparam int DW = 9;
    localparam int NL = 16;
    localparam int OW = DW + 1;
    localparam int HD = 16;

    typedef logic [NL*DW-1:0] in_vec_t;
    typedef logic [NL*OW-1:0] out_vec_t;
    typedef struct {
        out_vec_t si;
        out_vec_t sq;
        out_vec_t di;
        out_vec_t dq;
        logic     sop;
        logic     eop;
    } exp_t;

    logic     clk;
    logic     rstn;
    logic     din_valid;
    logic     din_sop;
    in_vec_t  din_i, din_q, dly_i, dly_q;
    logic     err_clr;
    logic     dout_valid, dout_sop, dout_eop, frame_err;
    out_vec_t sum_i, sum_q, diff_i, diff_q;

    exp_t sb[$];
    exp_t last;
    int   passed = 0;
    int   total  = 0;

    mod0_bfly_stage #(.DATA_WIDTH(DW), .NUM_LANES(NL), .HALF_DEPTH(HD)) dut (
        .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_sop(din_sop),
        .din_i(din_i), .din_q(din_q), .dly_i(dly_i), .dly_q(dly_q), .err_clr(err_clr),
        .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .sum_i(sum_i), .sum_q(sum_q), .diff_i(diff_i), .diff_q(diff_q), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    function automatic int model(input int a, input int b, input bit sub);
        int r;
        r = sub ? (a - b) : (a + b);
`ifdef MOD0_BFLY_SCALE_EN
        r = (r + 1) >>> 1;
`endif
        return r;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input out_vec_t obs, input out_vec_t exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        chk_bit("dout_valid", dout_valid, sb.size() != 0);
        if (dout_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk_vec("sum_i", sum_i, e.si);
            chk_vec("sum_q", sum_q, e.sq);
            chk_vec("diff_i", diff_i, e.di);
            chk_vec("diff_q", diff_q, e.dq);
            chk_bit("dout_sop", dout_sop, e.sop);
            chk_bit("dout_eop", dout_eop, e.eop);
            last = e;
        end else if (!dout_valid) begin
            chk_bit("idle_sop", dout_sop, 1'b0);
            chk_bit("idle_eop", dout_eop, 1'b0);
            chk_vec("hold_sum_i", sum_i, last.si);
            chk_vec("hold_diff_q", diff_q, last.dq);
        end
    endtask

    // Lane 0 I uses the directed values; every other operand is random.
    task automatic drive(input logic v, input logic s, input int di0, input int dy0,
                         input bit calc, input bit esop, input bit eeop);
        exp_t e;
        din_valid = v;
        din_sop   = s;
        for (int l = 0; l < NL; l++) begin
            int ai, bi, aq, bq;
            bi = (l == 0) ? di0 : rnd();
            ai = (l == 0) ? dy0 : rnd();
            aq = rnd();
            bq = rnd();
            din_i[l*DW +: DW] = DW'(bi);
            dly_i[l*DW +: DW] = DW'(ai);
            din_q[l*DW +: DW] = DW'(bq);
            dly_q[l*DW +: DW] = DW'(aq);
            e.si[l*OW +: OW] = OW'(model(ai, bi, 1'b0));
            e.di[l*OW +: OW] = OW'(model(ai, bi, 1'b1));
            e.sq[l*OW +: OW] = OW'(model(aq, bq, 1'b0));
            e.dq[l*OW +: OW] = OW'(model(aq, bq, 1'b1));
        end
        e.sop = esop;
        e.eop = eeop;
        if (calc) sb.push_back(e);
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic fill_half(input int val);
        drive(1'b1, 1'b1, val, rnd(), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < HD; k++) drive(1'b1, 1'b0, val, rnd(), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; din_valid = 1'b0; din_sop = 1'b0; err_clr = 1'b0;
        din_i = '0; din_q = '0; dly_i = '0; dly_q = '0;
        last = '{si: '0, sq: '0, di: '0, dq: '0, sop: 1'b0, eop: 1'b0};
        #12;
        chk_bit("rst_valid", dout_valid, 1'b0);
        chk_bit("rst_sop", dout_sop, 1'b0);
        chk_bit("rst_eop", dout_eop, 1'b0);
        chk_bit("rst_err", frame_err, 1'b0);
        chk_vec("rst_sum_i", sum_i, '0);
        chk_vec("rst_diff_i", diff_i, '0);
        rstn = 1'b1;

        // Nominal frame: lane0 I fill 3, calc din 5 against dly 3 -> sum 8, diff -2.
        fill_half(3);
        for (int k = 0; k < HD; k++) drive(1'b1, 1'b0, 5, 3, 1'b1, k == 0, k == HD - 1);

        // Back-to-back frame with full-scale operands.
        fill_half(-256);
        for (int k = 0; k < HD; k++)
            drive(1'b1, 1'b0, -256, (k % 2 == 0) ? -256 : 255, 1'b1, k == 0, k == HD - 1);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk_bit("nominal_err", frame_err, 1'b0);

        // Valid words without sop in IDLE are ignored.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        chk_bit("idle_junk_err", frame_err, 1'b0);

        // Gap at FILL word 10 with a simultaneous clear: the error must still set.
        drive(1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) drive(1'b1, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk_bit("gap_err_set", frame_err, 1'b1);
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk_bit("gap_err_sticky", frame_err, 1'b1);
        err_clr = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk_bit("gap_err_clr", frame_err, 1'b0);

        // Early sop at CALC word 5: five results, then the new frame runs to completion.
        fill_half(7);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b1, k == 0, 1'b0);
        drive(1'b1, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
        chk_bit("early_sop_err", frame_err, 1'b1);
        for (int k = 1; k < HD; k++) drive(1'b1, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < HD; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b1, k == 0, k == HD - 1);
        total++;
        assert (sb.size() == 0) begin
            passed++;
        end else begin
            $error("FAIL sb_drain: observed %0d pending, expected 0", sb.size());
        end

        // Asynchronous reset during CALC, with frame_err still set.
        fill_half(4);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b1, k == 0, 1'b0);
        rstn = 1'b0;
        #1;
        chk_bit("async_rst_valid", dout_valid, 1'b0);
        chk_bit("async_rst_err", frame_err, 1'b0);
        chk_vec("async_rst_sum_q", sum_q, '0);
        chk_vec("async_rst_diff_i", diff_i, '0);
        sb.delete();
        last = '{si: '0, sq: '0, di: '0, dq: '0, sop: 1'b0, eop: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
        fill_half(-1);
        for (int k = 0; k < HD; k++) drive(1'b1, 1'b0, rnd(), rnd(), 1'b1, k == 0, k == HD - 1);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk_bit("final_err", frame_err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
